alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
Operand-fetch and writeback sequencer for the 32-bit add/sub/xor ALU. It holds a small register file and accepts one instruction at a time over a valid/ready handshake. It drives the ALU's A/B/control inputs from registered operands, captures the ALU's combinational result one cycle later and writes it back to the destination register. A side load port initialises registers.

Parameters:
DATA_WIDTH, 32, datapath width; equals the ALU width.
REG_ADDR_WIDTH, 3, register index width; NUM_REGS = 2**REG_ADDR_WIDTH = 8.

Ports:
Clk  input  1  single clock, rising edge.
Reset  input  1  synchronous, active-high reset.
InstrValid  input  1  instruction offered.
InstrReady  output  1  unit can accept an instruction this cycle.
InstrOp  input  2  00 = ADD, 01 = XOR, 10 = SUB, 11 = illegal.
InstrRd  input  REG_ADDR_WIDTH  destination register.
InstrRs1  input  REG_ADDR_WIDTH  source A register.
InstrRs2  input  REG_ADDR_WIDTH  source B register.
LoadValid  input  1  write LoadData to LoadAddr.
LoadAddr  input  REG_ADDR_WIDTH  load target register.
LoadData  input  DATA_WIDTH  load value.
AluA  output  DATA_WIDTH  registered operand to ALU InputA.
AluB  output  DATA_WIDTH  registered operand to ALU InputB.
AluCtl  output  2  registered ALU control.
AluResult  input  DATA_WIDTH  combinational ALU Output.
DoneValid  output  1  one-cycle pulse: result written back.
DoneRd  output  REG_ADDR_WIDTH  register written.
DoneData  output  DATA_WIDTH  value written.
IllegalOp  output  1  one-cycle pulse: op 11 rejected.

Behaviour:
- Reset (synchronous, active-high): all registers are cleared to 0 and state goes to IDLE. AluA, AluB, AluCtl, DoneRd and DoneData are 0; DoneValid and IllegalOp are 0. Reset in EXEC abandons the instruction with no writeback and no DoneValid.
- Register 0 always reads 0. Writes to it (load or writeback) are discarded, but DoneValid still pulses with DoneRd = 0 and the computed DoneData.
- FSM states are IDLE and EXEC.
- InstrReady = (state == IDLE) && !LoadValid. Loads have priority; InstrReady never depends on InstrValid.
- A load is performed only in IDLE. LoadValid in EXEC is ignored; the source must hold it until the unit returns to IDLE.
- Accept: in IDLE with InstrValid && InstrReady, on that edge:
  - AluA <= reg[Rs1], AluB <= reg[Rs2], AluCtl <= InstrOp, latch Rd.
  - State -> EXEC.
  - If InstrOp == 11: stay in IDLE instead, pulse IllegalOp next cycle, leave the Alu* outputs unchanged, no writeback.
- EXEC (exactly 1 cycle):
  - On the edge: reg[Rd] <= AluResult; DoneValid = 1, DoneRd = Rd, DoneData = AluResult for the following cycle; state -> IDLE.
  - DoneData/DoneRd hold their value until the next writeback.
- Latency: accept edge to DoneValid = 2 cycles. Throughput is 1 instruction per 2 cycles.
- Dependent back-to-back instructions need no bypass. Writeback completes on the EXEC edge, before the next accept in IDLE reads the register file.
- Arithmetic is performed by the external ALU and is modulo 2**DATA_WIDTH (wrap, no flags). Rs1 == Rs2 == Rd is legal.
- AluA/AluB/AluCtl stay stable in IDLE (last issued values).

Decomposition:
- Shared package: opcode constants OP_ADD = 2'b00, OP_XOR = 2'b01, OP_SUB = 2'b10, OP_ILLEGAL = 2'b11; state encoding ST_IDLE/ST_EXEC.
- One sub-module: alu_regfile. It has 2 combinational read ports, 1 synchronous write port with write-enable and register-0 masking, and synchronous clear on Reset.
- The ALU itself is instantiated alongside the unit by the bench/top, not inside it.

Test Plan:
- Load R1 = 12, R2 = 4; issue ADD R3, R1, R2 -> AluA = 12, AluB = 4, AluCtl = 00 after accept; DoneValid 2 cycles after accept with DoneRd = 3, DoneData = 16.
- Load R1 = 20, R2 = 14; SUB R4, R1, R2 -> DoneData = 6. Then SUB R5, R2, R1 -> DoneData = 32'hFFFFFFFA (wrap).
- XOR R6, R1, R1 (R1 = 32'hA5A5A5A5) -> DoneData = 0. Then ADD R7, R6, R0 -> 0. Back-to-back issue: the dependent instruction reads the new R6.
- InstrOp = 11 -> IllegalOp pulses once, no DoneValid, register file unchanged, unit ready again the next cycle.
- LoadValid asserted together with InstrValid in IDLE -> InstrReady = 0, load performed, instruction accepted the next cycle. LoadValid in EXEC -> ignored.
- Reset asserted in EXEC of ADD R3 -> no DoneValid, R3 = 0, InstrReady = 1 the cycle after Reset deasserts. ADD R0, R1, R2 -> DoneValid with DoneRd = 0, R0 still reads 0.

Source files
------------

// File: rtl/alu_issue_unit_pkg.sv
// Shared opcode, state and sizing definitions for the ALU issue unit slice.
package alu_issue_unit_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_REG_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_XOR     = 2'b01,
    OP_SUB     = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction, load, ALU and writeback signals of the issue unit in one bundle.
interface alu_issue_unit_if
  import alu_issue_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
);

  logic                      instr_valid;
  logic                      instr_ready;
  logic [1:0]                instr_op;
  logic [REG_ADDR_WIDTH-1:0] instr_rd;
  logic [REG_ADDR_WIDTH-1:0] instr_rs1;
  logic [REG_ADDR_WIDTH-1:0] instr_rs2;
  logic                      load_valid;
  logic [REG_ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0]     load_data;
  logic [DATA_WIDTH-1:0]     alu_a;
  logic [DATA_WIDTH-1:0]     alu_b;
  logic [1:0]                alu_ctl;
  logic [DATA_WIDTH-1:0]     alu_result;
  logic                      done_valid;
  logic [REG_ADDR_WIDTH-1:0] done_rd;
  logic [DATA_WIDTH-1:0]     done_data;
  logic                      illegal_op;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    output load_valid, load_addr, load_data, alu_result,
    input  instr_ready, alu_a, alu_b, alu_ctl,
    input  done_valid, done_rd, done_data, illegal_op
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
    input  load_valid, load_addr, load_data, alu_result,
    output instr_ready, alu_a, alu_b, alu_ctl,
    output done_valid, done_rd, done_data, illegal_op
  );

endinterface

// File: rtl/alu_issue_unit_regfile.sv
// Register file with two combinational reads and one synchronous write; register 0 is hardwired to zero.
module alu_regfile
  import alu_issue_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [REG_ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0]     rdata1,
  input  logic [REG_ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0]     rdata2
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/alu_issue_unit.sv
// Operand-fetch / writeback sequencer for the external add/sub/xor ALU.
// Issues one instruction every two cycles: IDLE reads operands, EXEC writes the ALU result back.
module alu_issue_unit
  import alu_issue_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  alu_issue_unit_if.slave bus
);

  state_e                    state;
  state_e                    next_state;
  logic                      issue;
  logic                      illegal_accept;
  logic                      writeback;
  logic                      rf_we;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0]     rf_wdata;
  logic [DATA_WIDTH-1:0]     rs1_data;
  logic [DATA_WIDTH-1:0]     rs2_data;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]     alu_a_q;
  logic [DATA_WIDTH-1:0]     alu_b_q;
  logic [1:0]                alu_ctl_q;
  logic                      done_valid_q;
  logic [REG_ADDR_WIDTH-1:0] done_rd_q;
  logic [DATA_WIDTH-1:0]     done_data_q;
  logic                      illegal_q;

  alu_regfile #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr1(bus.instr_rs1),
    .rdata1(rs1_data),
    .raddr2(bus.instr_rs2),
    .rdata2(rs2_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Loads win over instructions in IDLE; the single write port is handed to writeback in EXEC.
  always_comb begin
    next_state     = state;
    issue          = 1'b0;
    illegal_accept = 1'b0;
    writeback      = 1'b0;
    rf_we          = 1'b0;
    rf_waddr       = bus.load_addr;
    rf_wdata       = bus.load_data;
    case (state)
      ST_IDLE: begin
        if (bus.load_valid) begin
          rf_we = 1'b1;
        end else if (bus.instr_valid) begin
          if (bus.instr_op == OP_ILLEGAL) begin
            illegal_accept = 1'b1;
          end else begin
            issue      = 1'b1;
            next_state = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        writeback  = 1'b1;
        rf_we      = 1'b1;
        rf_waddr   = rd_q;
        rf_wdata   = bus.alu_result;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q         <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctl_q    <= '0;
      done_valid_q <= 1'b0;
      done_rd_q    <= '0;
      done_data_q  <= '0;
      illegal_q    <= 1'b0;
    end else begin
      done_valid_q <= writeback;
      illegal_q    <= illegal_accept;
      if (issue) begin
        alu_a_q   <= rs1_data;
        alu_b_q   <= rs2_data;
        alu_ctl_q <= bus.instr_op;
        rd_q      <= bus.instr_rd;
      end
      if (writeback) begin
        done_rd_q   <= rd_q;
        done_data_q <= bus.alu_result;
      end
    end
  end

  assign bus.instr_ready = (state == ST_IDLE) && !bus.load_valid;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_ctl     = alu_ctl_q;
  assign bus.done_valid  = done_valid_q;
  assign bus.done_rd     = done_rd_q;
  assign bus.done_data   = done_data_q;
  assign bus.illegal_op  = illegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: directed scenarios plus randomized instruction
// streams checked against an array-based register model.
module tb_alu_issue_unit;
  import alu_issue_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [31:0] model_regs [8];
  logic [31:0] last_a;
  logic [31:0] last_b;
  logic [1:0]  last_ctl;

  alu_issue_unit_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(3)) bus ();

  alu_issue_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // External ALU sitting next to the unit.
  always_comb begin
    case (bus.alu_ctl)
      2'b00:   bus.alu_result = bus.alu_a + bus.alu_b;
      2'b01:   bus.alu_result = bus.alu_a ^ bus.alu_b;
      2'b10:   bus.alu_result = bus.alu_a - bus.alu_b;
      default: bus.alu_result = '0;
    endcase
  end

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned sum;
    case (op)
      2'b00:   sum = longint'(a) + longint'(b);
      2'b01:   sum = longint'(a ^ b);
      2'b10:   sum = 64'h1_0000_0000 + longint'(a) - longint'(b);
      default: sum = 0;
    endcase
    return sum[31:0];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model_regs[i] = '0;
    last_a = '0; last_b = '0; last_ctl = '0;
  endtask

  task automatic do_load(input logic [2:0] addr, input logic [31:0] data);
    bus.load_valid = 1'b1; bus.load_addr = addr; bus.load_data = data;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    if (addr != 3'd0) model_regs[addr] = data;
  endtask

  // Issues one instruction from IDLE and samples everything it produces; updates the model afterwards.
  task automatic drive_instr(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                             output logic rdy, output logic [31:0] a, output logic [31:0] b, output logic [1:0] ctl,
                             output logic dv_early, output logic ill, output logic dv, output logic [2:0] drd,
                             output logic [31:0] dd);
    logic [31:0] res;
    bus.instr_valid = 1'b1; bus.instr_op = op; bus.instr_rd = rd; bus.instr_rs1 = rs1; bus.instr_rs2 = rs2;
    #1 rdy = bus.instr_ready;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    a = bus.alu_a; b = bus.alu_b; ctl = bus.alu_ctl; dv_early = bus.done_valid; ill = bus.illegal_op;
    if (op != 2'b11) begin
      @(posedge clk); #1;
      res = ref_result(op, model_regs[rs1], model_regs[rs2]);
      last_a = model_regs[rs1]; last_b = model_regs[rs2]; last_ctl = op;
      if (rd != 3'd0) model_regs[rd] = res;
    end
    dv = bus.done_valid; drd = bus.done_rd; dd = bus.done_data;
  endtask

  task automatic probe(input logic [2:0] r, output logic [31:0] v);
    logic rdy, dve, ill, dv; logic [31:0] b, dd; logic [1:0] ctl; logic [2:0] drd;
    drive_instr(2'b00, 3'd0, r, 3'd0, rdy, v, b, ctl, dve, ill, dv, drd, dd);
  endtask

  task automatic test_reset();
    tests_run++; if (bus.alu_a !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_alu_a: got %0h expected 0", bus.alu_a); end
    tests_run++; if (bus.alu_b !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_alu_b: got %0h expected 0", bus.alu_b); end
    tests_run++; if (bus.alu_ctl !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_alu_ctl: got %0h expected 0", bus.alu_ctl); end
    tests_run++; if (bus.done_valid !== 1'b0 || bus.illegal_op !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pulses: got dv=%b ill=%b expected 0 0", bus.done_valid, bus.illegal_op); end
    tests_run++; if (bus.done_rd !== 3'd0 || bus.done_data !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_done: got rd=%0d data=%0h expected 0 0", bus.done_rd, bus.done_data); end
    tests_run++; if (bus.instr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.instr_ready); end
  endtask

  task automatic test_add();
    logic rdy, dve, ill, dv; logic [31:0] a, b, dd; logic [1:0] ctl; logic [2:0] drd;
    do_load(3'd1, 32'd12); do_load(3'd2, 32'd4);
    drive_instr(2'b00, 3'd3, 3'd1, 3'd2, rdy, a, b, ctl, dve, ill, dv, drd, dd);
    tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("[TB] FAIL add_ready: got %b expected 1", rdy); end
    tests_run++; if (a !== 32'd12 || b !== 32'd4 || ctl !== 2'b00) begin tests_failed++; $display("[TB] FAIL add_operands: got a=%0d b=%0d ctl=%0d expected 12 4 0", a, b, ctl); end
    tests_run++; if (dve !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_early_done: got %b expected 0", dve); end
    tests_run++; if (dv !== 1'b1 || drd !== 3'd3 || dd !== 32'd16) begin tests_failed++; $display("[TB] FAIL add_done: got v=%b rd=%0d data=%0d expected 1 3 16", dv, drd, dd); end
    @(posedge clk); #1;
    tests_run++; if (bus.done_valid !== 1'b0 || bus.done_data !== 32'd16) begin tests_failed++; $display("[TB] FAIL add_pulse_hold: got v=%b data=%0d expected 0 16", bus.done_valid, bus.done_data); end
  endtask

  task automatic test_sub();
    logic rdy, dve, ill, dv; logic [31:0] a, b, dd; logic [1:0] ctl; logic [2:0] drd;
    do_load(3'd1, 32'd20); do_load(3'd2, 32'd14);
    drive_instr(2'b10, 3'd4, 3'd1, 3'd2, rdy, a, b, ctl, dve, ill, dv, drd, dd);
    tests_run++; if (dv !== 1'b1 || drd !== 3'd4 || dd !== 32'd6) begin tests_failed++; $display("[TB] FAIL sub_done: got v=%b rd=%0d data=%0h expected 1 4 6", dv, drd, dd); end
    drive_instr(2'b10, 3'd5, 3'd2, 3'd1, rdy, a, b, ctl, dve, ill, dv, drd, dd);
    tests_run++; if (dv !== 1'b1 || drd !== 3'd5 || dd !== 32'hFFFF_FFFA) begin tests_failed++; $display("[TB] FAIL sub_wrap: got v=%b rd=%0d data=%0h expected 1 5 fffffffa", dv, drd, dd); end
  endtask

  task automatic test_back_to_back();
    logic rdy, dve, ill, dv; logic [31:0] a, b, dd; logic [1:0] ctl; logic [2:0] drd;
    do_load(3'd1, 32'hA5A5_A5A5); do_load(3'd6, 32'h0000_0055);
    drive_instr(2'b01, 3'd6, 3'd1, 3'd1, rdy, a, b, ctl, dve, ill, dv, drd, dd);
    tests_run++; if (dv !== 1'b1 || drd !== 3'd6 || dd !== 32'd0) begin tests_failed++; $display("[TB] FAIL xor_self: got v=%b rd=%0d data=%0h expected 1 6 0", dv, drd, dd); end
    drive_instr(2'b00, 3'd7, 3'd6, 3'd0, rdy, a, b, ctl, dve, ill, dv, drd, dd);
    tests_run++; if (rdy !== 1'b1 || a !== 32'd0) begin tests_failed++; $display("[TB] FAIL dependent_read: got rdy=%b a=%0h expected 1 0", rdy, a); end
    tests_run++; if (dv !== 1'b1 || drd !== 3'd7 || dd !== 32'd0) begin tests_failed++; $display("[TB] FAIL dependent_done: got v=%b rd=%0d data=%0h expected 1 7 0", dv, drd, dd); end
  endtask

  task automatic test_illegal();
    logic rdy, dve, ill, dv; logic [31:0] a, b, dd, v; logic [1:0] ctl; logic [2:0] drd;
    drive_instr(2'b11, 3'd1, 3'd2, 3'd3, rdy, a, b, ctl, dve, ill, dv, drd, dd);
    tests_run++; if (ill !== 1'b1 || dv !== 1'b0) begin tests_failed++; $display("[TB] FAIL illegal_pulse: got ill=%b dv=%b expected 1 0", ill, dv); end
    tests_run++; if (a !== last_a || b !== last_b || ctl !== last_ctl) begin tests_failed++; $display("[TB] FAIL illegal_alu_hold: got %0h %0h %0d expected %0h %0h %0d", a, b, ctl, last_a, last_b, last_ctl); end
    tests_run++; if (bus.instr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL illegal_ready: got %b expected 1", bus.instr_ready); end
    @(posedge clk); #1;
    tests_run++; if (bus.illegal_op !== 1'b0 || bus.done_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL illegal_once: got ill=%b dv=%b expected 0 0", bus.illegal_op, bus.done_valid); end
    probe(3'd1, v);
    tests_run++; if (v !== model_regs[1]) begin tests_failed++; $display("[TB] FAIL illegal_no_write: got R1=%0h expected %0h", v, model_regs[1]); end
  endtask

  task automatic test_load_priority();
    logic [31:0] exp_sum;
    bus.load_valid = 1'b1; bus.load_addr = 3'd1; bus.load_data = 32'h0000_0100;
    bus.instr_valid = 1'b1; bus.instr_op = 2'b00; bus.instr_rd = 3'd3; bus.instr_rs1 = 3'd1; bus.instr_rs2 = 3'd2;
    #1;
    tests_run++; if (bus.instr_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL load_blocks_ready: got %b expected 0", bus.instr_ready); end
    @(posedge clk); #1;
    bus.load_valid = 1'b0; model_regs[1] = 32'h0000_0100;
    #1;
    tests_run++; if (bus.instr_ready !== 1'b1 || bus.alu_ctl !== last_ctl) begin tests_failed++; $display("[TB] FAIL load_then_ready: got rdy=%b ctl=%0d expected 1 %0d", bus.instr_ready, bus.alu_ctl, last_ctl); end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    tests_run++; if (bus.alu_a !== 32'h0000_0100 || bus.alu_b !== model_regs[2]) begin tests_failed++; $display("[TB] FAIL load_then_accept: got a=%0h b=%0h expected 100 %0h", bus.alu_a, bus.alu_b, model_regs[2]); end
    exp_sum = ref_result(2'b00, model_regs[1], model_regs[2]);
    @(posedge clk); #1;
    tests_run++; if (bus.done_valid !== 1'b1 || bus.done_data !== exp_sum) begin tests_failed++; $display("[TB] FAIL load_then_done: got v=%b data=%0h expected 1 %0h", bus.done_valid, bus.done_data, exp_sum); end
    last_a = model_regs[1]; last_b = model_regs[2]; last_ctl = 2'b00; model_regs[3] = exp_sum;
  endtask

  task automatic test_load_in_exec();
    logic [31:0] exp_res, v;
    exp_res = ref_result(2'b00, model_regs[1], model_regs[2]);
    bus.instr_valid = 1'b1; bus.instr_op = 2'b00; bus.instr_rd = 3'd4; bus.instr_rs1 = 3'd1; bus.instr_rs2 = 3'd2;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.load_valid = 1'b1; bus.load_addr = 3'd5; bus.load_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    last_a = model_regs[1]; last_b = model_regs[2]; last_ctl = 2'b00; model_regs[4] = exp_res;
    tests_run++; if (bus.done_valid !== 1'b1 || bus.done_rd !== 3'd4 || bus.done_data !== exp_res) begin tests_failed++; $display("[TB] FAIL exec_load_done: got v=%b rd=%0d data=%0h expected 1 4 %0h", bus.done_valid, bus.done_rd, bus.done_data, exp_res); end
    probe(3'd5, v);
    tests_run++; if (v !== model_regs[5]) begin tests_failed++; $display("[TB] FAIL exec_load_ignored: got R5=%0h expected %0h", v, model_regs[5]); end
  endtask

  task automatic test_reset_in_exec();
    logic rdy, dve, ill, dv; logic [31:0] a, b, dd, v; logic [1:0] ctl; logic [2:0] drd;
    bus.instr_valid = 1'b1; bus.instr_op = 2'b00; bus.instr_rd = 3'd3; bus.instr_rs1 = 3'd1; bus.instr_rs2 = 3'd2;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; clear_model();
    tests_run++; if (bus.done_valid !== 1'b0 || bus.instr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_exec_abandon: got dv=%b rdy=%b expected 0 1", bus.done_valid, bus.instr_ready); end
    @(posedge clk); #1;
    tests_run++; if (bus.done_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_exec_no_done: got %b expected 0", bus.done_valid); end
    probe(3'd3, v);
    tests_run++; if (v !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset_exec_r3: got %0h expected 0", v); end
    do_load(3'd1, 32'd9); do_load(3'd2, 32'd5); do_load(3'd0, 32'h1234_5678);
    drive_instr(2'b00, 3'd0, 3'd1, 3'd2, rdy, a, b, ctl, dve, ill, dv, drd, dd);
    tests_run++; if (dv !== 1'b1 || drd !== 3'd0 || dd !== 32'd14) begin tests_failed++; $display("[TB] FAIL r0_done: got v=%b rd=%0d data=%0h expected 1 0 e", dv, drd, dd); end
    probe(3'd0, v);
    tests_run++; if (v !== 32'd0) begin tests_failed++; $display("[TB] FAIL r0_reads_zero: got %0h expected 0", v); end
  endtask

  task automatic test_random();
    logic rdy, dve, ill, dv; logic [31:0] a, b, dd, v, exp_a, exp_b, exp_d, hold_a, hold_b; logic [1:0] ctl, op, hold_ctl; logic [2:0] drd, rd, rs1, rs2;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) do_load(3'($urandom_range(0, 7)), $urandom);
      op = 2'($urandom_range(0, 3)); rd = 3'($urandom_range(0, 7));
      rs1 = 3'($urandom_range(0, 7)); rs2 = 3'($urandom_range(0, 7));
      exp_a = model_regs[rs1]; exp_b = model_regs[rs2]; exp_d = ref_result(op, exp_a, exp_b);
      hold_a = last_a; hold_b = last_b; hold_ctl = last_ctl;
      drive_instr(op, rd, rs1, rs2, rdy, a, b, ctl, dve, ill, dv, drd, dd);
      if (op == 2'b11) begin
        tests_run++; if (ill !== 1'b1 || dv !== 1'b0 || a !== hold_a || b !== hold_b || ctl !== hold_ctl) begin tests_failed++; $display("[TB] FAIL rand_illegal[%0d]: got ill=%b dv=%b a=%0h b=%0h ctl=%0d expected 1 0 %0h %0h %0d", n, ill, dv, a, b, ctl, hold_a, hold_b, hold_ctl); end
        @(posedge clk); #1;
      end else begin
        tests_run++; if (a !== exp_a || b !== exp_b || ctl !== op) begin tests_failed++; $display("[TB] FAIL rand_operands[%0d]: got a=%0h b=%0h ctl=%0d expected %0h %0h %0d", n, a, b, ctl, exp_a, exp_b, op); end
        tests_run++; if (dv !== 1'b1 || drd !== rd || dd !== exp_d) begin tests_failed++; $display("[TB] FAIL rand_done[%0d]: got v=%b rd=%0d data=%0h expected 1 %0d %0h", n, dv, drd, dd, rd, exp_d); end
      end
    end
    for (int r = 1; r < 8; r++) begin
      probe(3'(r), v);
      tests_run++; if (v !== model_regs[r]) begin tests_failed++; $display("[TB] FAIL rand_regfile[R%0d]: got %0h expected %0h", r, v, model_regs[r]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.instr_valid = 1'b0; bus.instr_op = 2'b00; bus.instr_rd = '0; bus.instr_rs1 = '0; bus.instr_rs2 = '0;
    bus.load_valid = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_illegal();
    test_load_priority();
    test_load_in_exec();
    test_reset_in_exec();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
